// File: rtl/channel_frame_reader.sv
// -----------------------------------------------------------------------------
// channel_frame_reader
//
// Read side of the multi-channel sample shift buffer. When a request is
// accepted, one channel's DEPTH-sample history is copied from the flattened
// buffer bus into a private snapshot. That snapshot is then streamed out as a
// byte frame over a valid/ready interface:
//   header (8'hA0 | channel), samples oldest-first, checksum.
// The checksum is the mod-256 sum of the header and every sample.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   buf_data     flattened buffer; channel c = [c*DEPTH*8 +: DEPTH*8],
//                sample 0 (oldest) in the low byte of the slice
//   req_valid    frame request valid
//   req_channel  requested channel index
//   req_ready    request accepted when req_valid && req_ready (idle only)
//   out_data     frame byte
//   out_valid    out_data valid
//   out_ready    downstream accepts a beat when out_valid && out_ready
//   out_last     marks the final (checksum) beat
//   busy         a frame is in progress
//   err_channel  one-cycle pulse after a request for a nonexistent channel
// -----------------------------------------------------------------------------
module channel_frame_reader #(
    parameter int NUM_CHANNELS = 14,
    parameter int DEPTH        = 10,
    parameter int SAMPLE_BITS  = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_CHANNELS*DEPTH*SAMPLE_BITS-1:0] buf_data,
    input  logic                                  req_valid,
    input  logic [3:0]                            req_channel,
    output logic                                  req_ready,
    output logic [7:0]                            out_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_last,
    output logic                                  busy,
    output logic                                  err_channel
);

    localparam int SLICE_BITS = DEPTH * 8;
    localparam int IW         = $clog2(DEPTH + 1);

    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [4:0]    NUM_CH   = 5'(NUM_CHANNELS);

    generate
        if (SAMPLE_BITS != 8) begin : g_bad_sample_bits
            $error("channel_frame_reader: SAMPLE_BITS must be 8");
        end
        if (NUM_CHANNELS < 1 || NUM_CHANNELS > 16) begin : g_bad_num_channels
            $error("channel_frame_reader: NUM_CHANNELS must be 1..16");
        end
        if (DEPTH < 2 || DEPTH > 255) begin : g_bad_depth
            $error("channel_frame_reader: DEPTH must be 2..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        SUM
    } state_t;

    state_t                state;
    logic [SLICE_BITS-1:0] snapshot;
    logic [SLICE_BITS-1:0] selected;
    logic [IW-1:0]         idx;
    logic [7:0]            checksum;
    logic                  channel_ok;

    // Channel slice picked by the current request.
    // NOTE: default assignment first so every path drives 'selected'; without
    // it the combinational block would infer a latch.
    always_comb begin
        selected = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (req_channel == 4'(c)) begin
                selected = buf_data[c*SLICE_BITS +: SLICE_BITS];
            end
        end
    end

    assign channel_ok = ({1'b0, req_channel} < NUM_CH);
    assign req_ready  = (state == IDLE) && !reset;
    assign busy       = (state != IDLE);

    // NOTE: all state uses non-blocking assignments so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // The snapshot is a plain register (not a RAM), so clearing it on
            // reset costs nothing and keeps a stale frame from leaking out.
            state       <= IDLE;
            snapshot    <= '0;
            idx         <= '0;
            checksum    <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            err_channel <= 1'b0;
        end else begin
            err_channel <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (channel_ok) begin
                            snapshot  <= selected;
                            idx       <= '0;
                            checksum  <= '0;
                            out_data  <= 8'hA0 | {4'h0, req_channel};
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
                            state     <= HDR;
                        end else begin
                            err_channel <= 1'b1;
                        end
                    end
                end

                HDR: begin
                    if (out_ready) begin
                        checksum <= checksum + out_data;
                        out_data <= snapshot[7:0];
                        state    <= DATA;
                    end
                end

                DATA: begin
                    if (out_ready) begin
                        checksum <= checksum + out_data;
                        if (idx == LAST_IDX) begin
                            // Running sum already holds header + earlier
                            // samples; add the beat leaving now.
                            out_data <= checksum + out_data;
                            out_last <= 1'b1;
                            state    <= SUM;
                        end else begin
                            // Shift the snapshot so the next sample is
                            // always in byte 1; byte 0 is the one on the bus.
                            snapshot <= snapshot >> 8;
                            out_data <= snapshot[15:8];
                            idx      <= idx + 1'b1;
                        end
                    end
                end

                SUM: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_frame_reader.sv
module tb_channel_frame_reader;

    localparam int NCH   = 14;
    localparam int DEPTH = 10;
    localparam int BW    = NCH * DEPTH * 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [BW-1:0] buf_data;
    logic          req_valid;
    logic [3:0]    req_channel;
    logic          req_ready;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          err_channel;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] last_beat;

    channel_frame_reader #(
        .NUM_CHANNELS (NCH),
        .DEPTH        (DEPTH),
        .SAMPLE_BITS  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .buf_data    (buf_data),
        .req_valid   (req_valid),
        .req_channel (req_channel),
        .req_ready   (req_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .err_channel (err_channel)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sample_of(input int ch, input int i);
        return buf_data[(ch*DEPTH + i)*8 +: 8];
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NCH*DEPTH; i++) buf_data[i*8 +: 8] = 8'($urandom);
    endtask

    task automatic set_channel_ramp(input int ch, input logic [7:0] base, input logic [7:0] step);
        for (int i = 0; i < DEPTH; i++) buf_data[(ch*DEPTH + i)*8 +: 8] = base + 8'(i) * step;
    endtask

    // Reference: build the whole expected frame from the buffer contents at
    // the moment of the request, then follow the handshake beat by beat.
    task automatic run_frame(input int ch, input int ready_pct, input bit scramble);
        logic [7:0] exp_q[$];
        logic [7:0] sum;
        logic       exp_last;
        bit         xfer;
        int         k;
        int         budget;
        exp_q = {};
        sum = 8'hA0 | 8'(ch);
        exp_q.push_back(sum);
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(sample_of(ch, i));
            sum = sum + sample_of(ch, i);
        end
        exp_q.push_back(sum);

        vectors++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL pre_req ch%0d: req_ready=%b busy=%b, need 1/0", ch, req_ready, busy);
        end
        req_valid   = 1'b1;
        req_channel = 4'(ch);
        tick();
        req_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL latency ch%0d: out_valid=%b busy=%b req_ready=%b, need 1/1/0",
                     ch, out_valid, busy, req_ready);
        end

        k = 0;
        budget = 0;
        out_ready = ($urandom_range(99) < ready_pct);
        while (k < DEPTH + 2 && budget < 400) begin
            if (scramble) fill_random();
            exp_last = (k == DEPTH + 1);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp_q[k] || out_last !== exp_last) begin
                miscompares++;
                $display("FAIL beat%0d ch%0d: valid=%b data=%h last=%b, need 1 %h %b",
                         k, ch, out_valid, out_data, out_last, exp_q[k], exp_last);
            end
            last_beat = out_data;
            xfer = out_ready;
            tick();
            if (xfer) k++;
            budget++;
            out_ready = ($urandom_range(99) < ready_pct);
        end
        if (budget >= 400) begin
            miscompares++;
            $display("FAIL timeout ch%0d: stuck at beat %0d", ch, k);
        end
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL frame_end ch%0d: valid=%b last=%b busy=%b req_ready=%b, need 0 0 0 1",
                     ch, out_valid, out_last, busy, req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        req_channel = '0;
        out_ready = 1'b0;
        buf_data = '0;
        repeat (3) tick();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 ||
            busy !== 1'b0 || err_channel !== 1'b0 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: valid=%b data=%h last=%b busy=%b err=%b req_ready=%b",
                     out_valid, out_data, out_last, busy, err_channel, req_ready);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: req_ready=%b out_valid=%b, need 1/0", req_ready, out_valid);
        end
    endtask

    task automatic test_basic_frame();
        fill_random();
        set_channel_ramp(3, 8'h10, 8'h01);
        run_frame(3, 100, 1'b0);
        vectors++;
        if (last_beat !== 8'h70) begin
            miscompares++;
            $display("FAIL basic_checksum: got %h need 70", last_beat);
        end
    endtask

    task automatic test_backpressure();
        set_channel_ramp(3, 8'h10, 8'h01);
        run_frame(3, 50, 1'b0);
        for (int n = 0; n < 4; n++) begin
            fill_random();
            run_frame(int'($urandom_range(NCH - 1)), 50, 1'b0);
        end
    endtask

    task automatic test_snapshot();
        fill_random();
        run_frame(3, 70, 1'b1);
        run_frame(int'($urandom_range(NCH - 1)), 40, 1'b1);
    endtask

    task automatic test_bad_channel();
        for (int ch = NCH; ch < 16; ch++) begin
            req_valid   = 1'b1;
            req_channel = 4'(ch);
            tick();
            req_valid = 1'b0;
            vectors++;
            if (err_channel !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL bad_ch%0d_pulse: err=%b valid=%b busy=%b req_ready=%b, need 1 0 0 1",
                         ch, err_channel, out_valid, busy, req_ready);
            end
            tick();
            vectors++;
            if (err_channel !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL bad_ch%0d_after: err=%b valid=%b busy=%b, need 0 0 0",
                         ch, err_channel, out_valid, busy);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        set_channel_ramp(3, 8'h40, 8'h03);
        req_valid   = 1'b1;
        req_channel = 4'd3;
        tick();
        req_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== sample_of(3, 5)) begin
            miscompares++;
            $display("FAIL mid_frame_beat: valid=%b data=%h, need 1 %h", out_valid, out_data, sample_of(3, 5));
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 ||
            busy !== 1'b0 || err_channel !== 1'b0 || req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: valid=%b data=%h last=%b busy=%b err=%b req_ready=%b",
                     out_valid, out_data, out_last, busy, err_channel, req_ready);
        end
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        run_frame(3, 100, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++) buf_data[(13*DEPTH + i)*8 +: 8] = 8'hFF;
        run_frame(13, 100, 1'b0);
        vectors++;
        if (last_beat !== 8'hA3) begin
            miscompares++;
            $display("FAIL wrap_checksum: got %h need a3", last_beat);
        end
        run_frame(13, 100, 1'b0);
        fill_random();
        run_frame(0, 60, 1'b0);
        run_frame(NCH - 1, 60, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_snapshot();
        test_bad_channel();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
